systolic_mac_array: RTL and testbench
=====================================

SYSTOLIC_MAC_ARRAY -- requirements
Module: systolic_mac_array

Interface
REQ-001 Parameter ROWS, default 4, array rows; range 1..16.
REQ-002 Parameter COLS, default 4, array columns; range 1..16.
REQ-003 Parameter DW, default 8, signed operand width.
REQ-004 Parameter AW, default 20, signed accumulator width; AW >= 2*DW.
REQ-005 Parameter KW, default 8, width of k_len.
REQ-006 Parameter SAT, default 0; 0 = wrapping accumulation, 1 = saturating accumulation.
REQ-007 sys_clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-010 k_len  in  KW  inner-dimension beat count; sampled with start.
REQ-011 a_in  in  ROWS*DW  one signed A element per row; row r in bits [r*DW +: DW].
REQ-012 b_in  in  COLS*DW  one signed B element per column; column c in bits [c*DW +: DW].
REQ-013 in_valid / in_ready  in / out  1 each  input beat handshake; transfer when both are high.
REQ-014 out_data  out  COLS*AW  one result row; column c in bits [c*AW +: AW].
REQ-015 out_row  out  ceil(log2(ROWS)) or 1 bit  index of the row on out_data.
REQ-016 out_valid / out_ready  out / in  1 each  result handshake.
REQ-017 out_last  out  1  high with the final row (out_row = ROWS-1).
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL use states IDLE, LOAD, FLUSH and DRAIN.
REQ-020 In IDLE, start SHALL latch k_len and clear all ROWS*COLS accumulators.
REQ-021 From IDLE, start with k_len > 0 SHALL move to LOAD; start with k_len = 0 SHALL move to DRAIN.
REQ-022 in_ready SHALL be 1 only in LOAD, with no combinational path from in_valid.
REQ-023 Row r input SHALL pass through an r-stage skew delay and column c input through a c-stage skew delay; row 0 and column 0 have no delay.
REQ-024 Cell (r,c) SHALL pass its A operand right and its B operand down through one register each.
REQ-025 Skew registers, pass registers and accumulators SHALL advance only on an "advance" cycle: an accepted beat in LOAD, or any cycle in FLUSH; otherwise they hold.
REQ-026 On each advance, each cell SHALL add the full 2*DW signed product of its A and B operands, sign-extended to AW, to its accumulator.
REQ-027 SAT=0: the sum SHALL wrap modulo 2^AW; SAT=1: the sum SHALL clamp to [-2^(AW-1), 2^(AW-1)-1].
REQ-028 On the k_len-th accepted beat, the FSM SHALL leave LOAD: to FLUSH if ROWS+COLS > 2, else to DRAIN.
REQ-029 FLUSH SHALL last exactly ROWS+COLS-2 cycles, injecting zero operands at both array edges.
REQ-030 After FLUSH, accumulator (r,c) SHALL equal the sum over t of A[t][r]*B[t][c] for t in 0..k_len-1, subject to REQ-027.
REQ-031 DRAIN SHALL present rows 0..ROWS-1 in order with out_valid = 1, advancing out_row only on out_valid & out_ready.
REQ-032 While out_valid is high and out_ready is low, out_data, out_row and out_last SHALL stay stable.
REQ-033 Accepting the out_last row SHALL return the FSM to IDLE; accumulators keep their values until the next start.
REQ-034 start outside IDLE SHALL be ignored; in_valid outside LOAD SHALL be ignored.

Reset
REQ-035 Asserting sys_rst_n low SHALL immediately force IDLE and zero all skew registers, pass registers, accumulators and counters.
REQ-036 During reset, outputs SHALL be: in_ready=0, out_valid=0, out_last=0, busy=0, out_row=0, out_data=0.
REQ-037 Reset asserted mid-job (any state) SHALL abort the job with no result output; the first start after release SHALL run normally.

Verification (defaults unless noted)
REQ-038 Identity: k_len=4, A = I, B rows {1,2,3,4}, {5,6,7,8}, {-1,-2,-3,-4}, {9,10,11,12}, in_valid held high -> four rows out equal B; FLUSH lasts 6 cycles; out_last set on row 3.
REQ-039 Input gaps: same stimulus as REQ-038 with in_valid low on alternate cycles -> identical out_data; in_ready stays high throughout LOAD.
REQ-040 Overflow: DW=8, AW=16, k_len=4, all operands -128 -> with SAT=1 every element is 32767; with SAT=0 every element is 0.
REQ-041 Backpressure: out_ready low for 5 cycles while row 1 is presented -> out_data and out_row=1 stable for 5 cycles; no row skipped or repeated.
REQ-042 Zero length: start with k_len=0 -> busy=1, no LOAD (in_ready never high), four zero rows, then IDLE.
REQ-043 Abort: sys_rst_n low for 1 cycle during FLUSH -> all outputs zero at once; a new REQ-038 job then returns the correct result.

Source files
------------

// File: rtl/systolic_mac_array.sv
// Output-stationary systolic MAC array.
// Streams of A (one element per row) and B (one element per column) are
// skewed so that beat t meets in cell (r,c) on advance t+r+c. Each cell
// accumulates A*B, and the finished accumulators are read out one row per
// handshake.
//
// Handshakes: a beat transfers on a rising edge where valid and ready are
// both high. Ready never depends combinationally on valid. A producer holding
// valid keeps its payload stable until the transfer.
module systolic_mac_array #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 20,
    parameter int KW   = 8,
    parameter int SAT  = 0
) (
    input  logic                                      sys_clk,
    input  logic                                      sys_rst_n,
    input  logic                                      start,
    input  logic [KW-1:0]                             k_len,
    input  logic [ROWS*DW-1:0]                        a_in,
    input  logic [COLS*DW-1:0]                        b_in,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [COLS*AW-1:0]                        out_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      out_last,
    output logic                                      busy,
    output logic [1:0]                                fsm_state
);

    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW        = $clog2(ROWS + COLS);
    localparam int FLUSH_LEN = ROWS + COLS - 2;
    // Triangular skew storage: row r owns r registers starting at r*(r-1)/2.
    localparam int ASN       = (ROWS > 1) ? (ROWS * (ROWS - 1)) / 2 : 1;
    localparam int BSN       = (COLS > 1) ? (COLS * (COLS - 1)) / 2 : 1;
    localparam int APW       = (COLS > 1) ? COLS - 1 : 1;
    localparam int BPH       = (ROWS > 1) ? ROWS - 1 : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    state;
    logic [KW-1:0] k_lat;
    logic [KW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] row_cnt;

    logic beat_fire;
    logic last_beat;
    logic out_fire;
    logic adv;
    logic job_start;

    logic [DW-1:0] a_edge [ROWS];
    logic [DW-1:0] b_edge [COLS];
    logic [DW-1:0] a_skw  [ROWS];
    logic [DW-1:0] b_skw  [COLS];
    logic [DW-1:0] a_sk   [ASN];
    logic [DW-1:0] b_sk   [BSN];
    logic [DW-1:0] a_op   [ROWS][COLS];
    logic [DW-1:0] b_op   [ROWS][COLS];
    logic [DW-1:0] a_pass [ROWS][APW];
    logic [DW-1:0] b_pass [BPH][COLS];
    logic [AW-1:0] acc    [ROWS][COLS];
    logic [AW-1:0] acc_nxt[ROWS][COLS];

    assign job_start = (state == IDLE) && start;
    assign beat_fire = (state == LOAD) && in_valid;
    assign last_beat = beat_fire && (beat_cnt == k_lat - KW'(1));
    assign out_fire  = out_valid && out_ready;
    // The whole array moves together: on accepted beats and throughout FLUSH.
    assign adv       = beat_fire || (state == FLUSH);

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign out_row   = row_cnt;
    assign out_last  = (state == DRAIN) && (row_cnt == RW'(ROWS - 1));
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    // Job sequencing: IDLE -> LOAD (k beats) -> FLUSH (skew drain) -> DRAIN.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            k_lat     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k_lat     <= k_len;
                        beat_cnt  <= '0;
                        flush_cnt <= '0;
                        row_cnt   <= '0;
                        state     <= (k_len != '0) ? LOAD : DRAIN;
                    end
                end
                LOAD: begin
                    if (beat_fire) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= (ROWS + COLS > 2) ? FLUSH : DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + KW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
                        flush_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (row_cnt == RW'(ROWS - 1)) begin
                            row_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            row_cnt <= row_cnt + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array edges: live operands while loading, zeros while flushing.
    for (genvar r = 0; r < ROWS; r++) begin : g_arow
        assign a_edge[r] = (state == LOAD) ? a_in[r*DW +: DW] : '0;
        if (r == 0) begin : g_nodly
            assign a_skw[r] = a_edge[r];
        end else begin : g_dly
            assign a_skw[r] = a_sk[(r * (r - 1)) / 2 + r - 1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bcol
        assign b_edge[c] = (state == LOAD) ? b_in[c*DW +: DW] : '0;
        if (c == 0) begin : g_nodly
            assign b_skw[c] = b_edge[c];
        end else begin : g_dly
            assign b_skw[c] = b_sk[(c * (c - 1)) / 2 + c - 1];
        end
    end

    // Per-cell operand routing and multiply-accumulate (wrapping or clamped).
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_cell
            logic signed [2*DW-1:0] prod;
            logic signed [AW:0]     sum;
            logic                   ovf;

            if (c == 0) begin : g_aw
                assign a_op[r][c] = a_skw[r];
            end else begin : g_ap
                assign a_op[r][c] = a_pass[r][c-1];
            end

            if (r == 0) begin : g_bn
                assign b_op[r][c] = b_skw[c];
            end else begin : g_bp
                assign b_op[r][c] = b_pass[r-1][c];
            end

            assign prod = (2*DW)'($signed(a_op[r][c])) * (2*DW)'($signed(b_op[r][c]));
            assign sum  = (AW+1)'($signed(acc[r][c])) + (AW+1)'(prod);
            // One extra sum bit holds the true sign; disagreement means overflow.
            assign ovf  = (SAT != 0) && (sum[AW] != sum[AW-1]);
            assign acc_nxt[r][c] = !ovf ? sum[AW-1:0]
                                 : (sum[AW] ? {1'b1, {(AW-1){1'b0}}}
                                            : {1'b0, {(AW-1){1'b1}}});
        end
    end

    // Skew chains, pass registers and accumulators: clear on start, step on advance.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < ASN; i++) a_sk[i] <= '0;
            for (int i = 0; i < BSN; i++) b_sk[i] <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < APW; c++) a_pass[r][c] <= '0;
            for (int r = 0; r < BPH; r++)
                for (int c = 0; c < COLS; c++) b_pass[r][c] <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) acc[r][c] <= '0;
        end else if (job_start) begin
            for (int i = 0; i < ASN; i++) a_sk[i] <= '0;
            for (int i = 0; i < BSN; i++) b_sk[i] <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < APW; c++) a_pass[r][c] <= '0;
            for (int r = 0; r < BPH; r++)
                for (int c = 0; c < COLS; c++) b_pass[r][c] <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) acc[r][c] <= '0;
        end else if (adv) begin
            // Shift the packed storage as one line, then overwrite each chain head;
            // the later head assignment wins over the cross-chain shift.
            for (int i = 1; i < ASN; i++) a_sk[i] <= a_sk[i-1];
            for (int r = 1; r < ROWS; r++) a_sk[(r * (r - 1)) / 2] <= a_edge[r];
            for (int i = 1; i < BSN; i++) b_sk[i] <= b_sk[i-1];
            for (int c = 1; c < COLS; c++) b_sk[(c * (c - 1)) / 2] <= b_edge[c];
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS - 1; c++) a_pass[r][c] <= a_op[r][c];
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) b_pass[r][c] <= b_op[r][c];
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) acc[r][c] <= acc_nxt[r][c];
        end
    end

    // Result row mux; zero whenever no row is being presented.
    always_comb begin
        out_data = '0;
        if (state == DRAIN) begin
            for (int c = 0; c < COLS; c++) out_data[c*AW +: AW] = acc[row_cnt][c];
        end
    end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Bench for systolic_mac_array: identity, input gaps, overflow (wrap and
// clamp at AW=16), output backpressure, zero length and mid-job reset.
module tb_systolic_mac_array;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 20;
    localparam int KW   = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic [ROWS*DW-1:0]   a_in;
    logic [COLS*DW-1:0]   b_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [COLS*AW-1:0]   out_data;
    logic [1:0]           out_row;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic [1:0]           fsm_state;

    logic                 in_ready_s, out_valid_s, out_last_s, busy_s;
    logic [COLS*16-1:0]   out_data_s;
    logic [1:0]           out_row_s, fsm_state_s;
    logic                 in_ready_w, out_valid_w, out_last_w, busy_w;
    logic [COLS*16-1:0]   out_data_w;
    logic [1:0]           out_row_w, fsm_state_w;

    int checks = 0;
    int errors = 0;

    logic [COLS*AW-1:0] exp_q[$];

    int ta [16][ROWS];
    int tb [16][COLS];
    int kcur;

    systolic_mac_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .KW(KW), .SAT(0)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .k_len(k_len),
        .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .fsm_state(fsm_state)
    );

    systolic_mac_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(16), .KW(KW), .SAT(1)) dut_sat (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .k_len(k_len),
        .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready_s),
        .out_data(out_data_s), .out_row(out_row_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_last(out_last_s), .busy(busy_s), .fsm_state(fsm_state_s)
    );

    systolic_mac_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(16), .KW(KW), .SAT(0)) dut_wrap (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .k_len(k_len),
        .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready_w),
        .out_data(out_data_w), .out_row(out_row_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_last(out_last_w), .busy(busy_w), .fsm_state(fsm_state_w)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_identity();
        int bm [4][4];
        bm = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{-1, -2, -3, -4}, '{9, 10, 11, 12}};
        kcur = 4;
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < ROWS; r++) ta[t][r] = (t == r) ? 1 : 0;
            for (int c = 0; c < COLS; c++) tb[t][c] = bm[t][c];
        end
    endtask

    task automatic set_const(input int k, input int v);
        kcur = k;
        for (int t = 0; t < k; t++) begin
            for (int r = 0; r < ROWS; r++) ta[t][r] = v;
            for (int c = 0; c < COLS; c++) tb[t][c] = v;
        end
    endtask

    // Reference model: C = A^T * B over the current beats, wrapped to AW.
    task automatic push_expected();
        logic [COLS*AW-1:0] row;
        int s;
        for (int r = 0; r < ROWS; r++) begin
            row = '0;
            for (int c = 0; c < COLS; c++) begin
                s = 0;
                for (int t = 0; t < kcur; t++) s += ta[t][r] * tb[t][c];
                row[c*AW +: AW] = s[AW-1:0];
            end
            exp_q.push_back(row);
        end
    endtask

    // Issues start and streams kcur beats; entered and left at posedge+1.
    task automatic drive_job(input bit gaps, output int drops);
        int  t;
        int  guard;
        bit  toggle;
        bit  fire;
        drops  = 0;
        k_len  = KW'(kcur);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        k_len  = '0;
        t      = 0;
        guard  = 0;
        toggle = 1'b0;
        while (t < kcur && guard < 200) begin
            in_valid = gaps ? toggle : 1'b1;
            toggle   = ~toggle;
            for (int r = 0; r < ROWS; r++) a_in[r*DW +: DW] = 8'(ta[t][r]);
            for (int c = 0; c < COLS; c++) b_in[c*DW +: DW] = 8'(tb[t][c]);
            if (!in_ready) drops++;
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (fire) t++;
        end
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        if (t != kcur) drops += 1000;
        push_expected();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b0000 || out_row !== 2'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/val/last/busy=%b row=%0d data=%h, required all zero",
                     {in_ready, out_valid, out_last, busy}, out_row, out_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        int drops, cnt, w;
        logic [COLS*AW-1:0] exp;
        set_identity();
        drive_job(1'b0, drops);
        cnt = 0;
        while (!out_valid && cnt < 50) begin cnt++; @(posedge clk); #1; end
        checks++;
        if (cnt != 6) begin
            errors++;
            $display("FAIL identity_flush_len: got %0d cycles, required 6", cnt);
        end
        for (int r = 0; r < ROWS; r++) begin
            w = 0;
            while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_row !== 2'(r) || out_last !== (r == ROWS-1)) begin
                errors++;
                $display("FAIL identity_ctl row %0d: valid=%b row=%0d last=%b, required 1 %0d %b",
                         r, out_valid, out_row, out_last, r, (r == ROWS-1));
            end
            checks++;
            if (out_data !== exp) begin
                errors++;
                $display("FAIL identity_data row %0d: got %h required %h", r, out_data, exp);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL identity_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_gaps();
        int drops, w;
        logic [COLS*AW-1:0] exp;
        set_identity();
        drive_job(1'b1, drops);
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL gaps_in_ready: %0d LOAD cycles without in_ready, required 0", drops);
        end
        for (int r = 0; r < ROWS; r++) begin
            w = 0;
            while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_row !== 2'(r) || out_data !== exp) begin
                errors++;
                $display("FAIL gaps_data row %0d: valid=%b row=%0d data=%h, required 1 %0d %h",
                         r, out_valid, out_row, out_data, r, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overflow();
        int drops, w;
        logic [COLS*AW-1:0] exp;
        logic [COLS*16-1:0] exp_sat, exp_wrap;
        exp_sat  = {COLS{16'h7fff}};
        exp_wrap = '0;
        set_const(4, -128);
        drive_job(1'b0, drops);
        for (int r = 0; r < ROWS; r++) begin
            w = 0;
            while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                errors++;
                $display("FAIL overflow_wide row %0d: valid=%b data=%h, required 1 %h", r, out_valid, out_data, exp);
            end
            checks++;
            if (out_valid_s !== 1'b1 || out_data_s !== exp_sat) begin
                errors++;
                $display("FAIL overflow_sat row %0d: valid=%b data=%h, required 1 %h", r, out_valid_s, out_data_s, exp_sat);
            end
            checks++;
            if (out_valid_w !== 1'b1 || out_data_w !== exp_wrap) begin
                errors++;
                $display("FAIL overflow_wrap row %0d: valid=%b data=%h, required 1 %h", r, out_valid_w, out_data_w, exp_wrap);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int drops, w;
        logic [COLS*AW-1:0] exp;
        set_identity();
        drive_job(1'b0, drops);
        for (int r = 0; r < ROWS; r++) begin
            w = 0;
            while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_row !== 2'(r) || out_data !== exp) begin
                errors++;
                $display("FAIL bp_row %0d: valid=%b row=%0d data=%h, required 1 %0d %h",
                         r, out_valid, out_row, out_data, r, exp);
            end
            if (r == 1) begin
                out_ready = 1'b0;
                start     = 1'b1;
                k_len     = 8'd2;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (out_valid !== 1'b1 || out_row !== 2'd1 || out_last !== 1'b0 || out_data !== exp) begin
                        errors++;
                        $display("FAIL bp_stall cycle %0d: valid=%b row=%0d last=%b data=%h, required 1 1 0 %h",
                                 s, out_valid, out_row, out_last, out_data, exp);
                    end
                end
                start     = 1'b0;
                k_len     = '0;
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_zero_len();
        int w;
        bit rdy_seen;
        logic [COLS*AW-1:0] exp;
        rdy_seen = 1'b0;
        kcur     = 0;
        push_expected();
        k_len = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_busy: busy=%b required 1", busy);
        end
        for (int r = 0; r < ROWS; r++) begin
            w = 0;
            while (!out_valid && w < 50) begin
                rdy_seen |= in_ready;
                @(posedge clk); #1; w++;
            end
            rdy_seen |= in_ready;
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_row !== 2'(r) || out_data !== exp) begin
                errors++;
                $display("FAIL zero_row %0d: valid=%b row=%0d data=%h, required 1 %0d %h",
                         r, out_valid, out_row, out_data, r, exp);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rdy_seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_end: in_ready_seen=%b busy=%b, required 0 0", rdy_seen, busy);
        end
    endtask

    task automatic test_abort();
        int drops, nvalid;
        set_identity();
        drive_job(1'b0, drops);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b0000 || out_row !== 2'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL abort_outputs: rdy/val/last/busy=%b row=%0d data=%h, required all zero",
                     {in_ready, out_valid, out_last, busy}, out_row, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid || busy) nvalid++;
            @(posedge clk); #1;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL abort_no_result: %0d cycles with valid/busy, required 0", nvalid);
        end
        test_identity();
    endtask

    // ---------------- sequence ----------------
    initial begin
        start     = 1'b0;
        k_len     = '0;
        a_in      = '0;
        b_in      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        test_reset();
        test_identity();
        test_gaps();
        test_overflow();
        test_backpressure();
        test_zero_len();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
